// File: rtl/ws2812_pixel_buffer.sv
// ws2812_pixel_buffer
//   Double-buffered pixel store in front of the WS2812 serial controller.
//   Host writes land in the shadow bank after brightness scaling and
//   reordering into the controller's LSB-first transmit order. A commit
//   request swaps shadow and active banks only when the controller's
//   data_index wraps from the last pixel back to 0. This keeps each
//   transmitted frame consistent.
//
// Ports
//   clock, reset    : system clock, synchronous active-high reset
//   wr_valid/ready  : pixel write handshake (ready drops while a commit waits)
//   wr_addr, wr_rgb : pixel index and {R,G,B} colour
//   brightness      : global scale, sampled with the accepted write
//   commit          : request a bank swap at the next frame boundary
//   commit_pending  : swap requested but not yet performed
//   swap            : one-cycle pulse on the cycle the banks swap
//   wr_error        : one-cycle pulse for an accepted write past RGB_NUM-1
//   data_index      : pixel index currently requested by the controller
//   data_in         : active-bank pixel in serial order (combinational)
module ws2812_pixel_buffer #(
  parameter int RGB_NUM_WIDTH = 4,
  parameter int RGB_NUM       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RGB_NUM_WIDTH-1:0] wr_addr,
  input  logic [23:0]              wr_rgb,
  input  logic [7:0]               brightness,
  input  logic                     commit,
  output logic                     commit_pending,
  output logic                     swap,
  output logic                     wr_error,
  input  logic [RGB_NUM_WIDTH-1:0] data_index,
  output logic [23:0]              data_in
);

  localparam int DATA_W = 24;
  localparam int COEF_W = 8;
  localparam int IDX_W  = (RGB_NUM > 1) ? $clog2(RGB_NUM) : 1;
  localparam logic [RGB_NUM_WIDTH:0]   NUM_EXT  = (RGB_NUM_WIDTH+1)'(RGB_NUM);
  localparam logic [RGB_NUM_WIDTH-1:0] LAST_IDX = RGB_NUM_WIDTH'(RGB_NUM - 1);

  // c * (b + 1) >> 8: b = 255 is identity, b = 0 blanks the channel.
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [COEF_W-1:0] b);
    logic [16:0] prod;
    prod = {9'b0, c} * ({9'b0, b} + 17'd1);
    return prod[15:8];
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k] = v[7-k];
    end
    return r;
  endfunction

  // The controller shifts bit 0 out first while the LED expects G7 first,
  // so each channel is bit-reversed and the channels ordered B:R:G.
  function automatic logic [DATA_W-1:0] pack_word(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {bit_rev8(b), bit_rev8(r), bit_rev8(g)};
  endfunction

  logic [DATA_W-1:0]        bank [0:1][0:RGB_NUM-1];
  logic                     sel;
  logic [RGB_NUM_WIDTH-1:0] idx_q;
  logic                     frame_done;

  logic                     accept_p0;
  logic [DATA_W-1:0]        word_p0;

  logic                     vld_p1;
  logic [RGB_NUM_WIDTH-1:0] addr_p1;
  logic [DATA_W-1:0]        word_p1;
  logic                     in_range_p1;

  // ---- stage p0: handshake, scaling and reorder on the acceptance cycle
  assign wr_ready  = !commit_pending;
  assign accept_p0 = wr_valid && wr_ready;
  assign word_p0   = pack_word(scale_chan(wr_rgb[23:16], brightness),
                               scale_chan(wr_rgb[15:8],  brightness),
                               scale_chan(wr_rgb[7:0],   brightness));

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept_p0) begin
      addr_p1 <= wr_addr;
      word_p1 <= word_p0;
    end
  end

  // ---- stage p1: write into the shadow bank (sel as it was before the edge)
  assign in_range_p1 = ({1'b0, addr_p1} < NUM_EXT);
  assign wr_error    = vld_p1 && !in_range_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < RGB_NUM; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else if (vld_p1 && in_range_p1) begin
      bank[~sel][addr_p1[IDX_W-1:0]] <= word_p1;
    end
  end

  // ---- frame boundary and bank swap
  assign frame_done = (idx_q == LAST_IDX) && (data_index == '0);
  assign swap       = commit_pending && frame_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q          <= '0;
      sel            <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      idx_q <= data_index;
      if (swap) begin
        sel            <= ~sel;
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // ---- read path: combinational lookup into the active bank
  always_comb begin
    data_in = '0;
    if ({1'b0, data_index} < NUM_EXT) begin
      data_in = bank[sel][data_index[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_buffer.sv
module tb_ws2812_pixel_buffer;

  localparam int W = 4;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  wr_addr = '0;
  logic [23:0]   wr_rgb = '0;
  logic [7:0]    brightness = '0;
  logic          commit = 1'b0;
  logic          commit_pending;
  logic          swap;
  logic          wr_error;
  logic [W-1:0]  data_index = '0;
  logic [23:0]   data_in;

  ws2812_pixel_buffer #(.RGB_NUM_WIDTH(W), .RGB_NUM(N)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_rgb(wr_rgb), .brightness(brightness), .commit(commit),
    .commit_pending(commit_pending), .swap(swap), .wr_error(wr_error),
    .data_index(data_index), .data_in(data_in)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [23:0]  w;
  } sb_t;

  sb_t         sb[$];
  logic [23:0] model_bank [0:1][0:N-1];
  logic        model_sel;
  int          total = 0;
  int          passed = 0;

  // Reference: integer scaling and explicit per-bit placement.
  function automatic logic [23:0] exp_word(input logic [23:0] rgb, input logic [7:0] br);
    int r, g, b;
    logic [7:0] rs, gs, bs;
    logic [23:0] w;
    r = (int'(rgb[23:16]) * (int'(br) + 1)) / 256;
    g = (int'(rgb[15:8])  * (int'(br) + 1)) / 256;
    b = (int'(rgb[7:0])   * (int'(br) + 1)) / 256;
    rs = r[7:0]; gs = g[7:0]; bs = b[7:0];
    for (int k = 0; k < 8; k++) begin
      w[k]      = gs[7-k];
      w[8 + k]  = rs[7-k];
      w[16 + k] = bs[7-k];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        model_bank[b][i] = '0;
    model_sel = 1'b0;
    sb.delete();
  endtask

  // One-cycle write; with cm set, commit is raised in the same cycle.
  task automatic write_px(input logic [W-1:0] a, input logic [23:0] rgb,
                          input logic [7:0] br, input logic cm);
    logic exp_err;
    sb_t  e;
    wr_valid = 1'b1; wr_addr = a; wr_rgb = rgb; brightness = br; commit = cm;
    #1;
    total++;
    if (wr_ready !== 1'b1) $display("FAIL wr_ready_on_write addr=%0d got=%b want=1", a, wr_ready);
    else passed++;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    #1;
    exp_err = (int'(a) >= N);
    total++;
    if (wr_error !== exp_err) $display("FAIL wr_error addr=%0d got=%b want=%b", a, wr_error, exp_err);
    else passed++;
    if (!exp_err) begin
      model_bank[!model_sel][a] = exp_word(rgb, br);
      e.a = a; e.w = exp_word(rgb, br);
      sb.push_back(e);
    end
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    #1;
    total++;
    if (commit_pending !== 1'b1 || wr_ready !== 1'b0)
      $display("FAIL commit_set pending=%b ready=%b want pending=1 ready=0", commit_pending, wr_ready);
    else passed++;
  endtask

  // Drive data_index 7 then 0 and check the swap pulse and its aftermath.
  task automatic wrap_frame(input logic expect_swap);
    data_index = 4'd7;
    tick();
    data_index = 4'd0;
    #1;
    total++;
    if (swap !== expect_swap) $display("FAIL swap_pulse got=%b want=%b", swap, expect_swap);
    else passed++;
    tick();
    if (expect_swap) model_sel = !model_sel;
    #1;
    total++;
    if (swap !== 1'b0 || commit_pending !== 1'b0 || wr_ready !== 1'b1)
      $display("FAIL after_wrap swap=%b pending=%b ready=%b want 0/0/1", swap, commit_pending, wr_ready);
    else passed++;
  endtask

  // Pop every scoreboard entry and compare, then scan all indices.
  task automatic check_frame(input string tag);
    sb_t e;
    logic [23:0] exp;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      data_index = e.a;
      #1;
      total++;
      if (data_in !== e.w) $display("FAIL %s sb idx=%0d got=%h want=%h", tag, e.a, data_in, e.w);
      else passed++;
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      data_index = 4'(i);
      #1;
      exp = (i < N) ? model_bank[model_sel][i] : 24'h0;
      total++;
      if (data_in !== exp) $display("FAIL %s scan idx=%0d got=%h want=%h", tag, i, data_in, exp);
      else passed++;
      tick();
    end
    data_index = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (wr_ready !== 1'b1 || commit_pending !== 1'b0 || swap !== 1'b0 || wr_error !== 1'b0)
      $display("FAIL reset_ctrl ready=%b pending=%b swap=%b err=%b want 1/0/0/0",
               wr_ready, commit_pending, swap, wr_error);
    else passed++;
    check_frame("reset");
  endtask

  task automatic test_write_commit();
    write_px(4'd3, 24'hFF0000, 8'd255, 1'b0);
    do_commit();
    wrap_frame(1'b1);
    data_index = 4'd3;
    #1;
    total++;
    if (data_in !== 24'h00FF00) $display("FAIL red_literal got=%h want=00ff00", data_in);
    else passed++;
    check_frame("write_commit");
  endtask

  task automatic test_scaling();
    write_px(4'd5, 24'h8001FF, 8'd127, 1'b0);
    do_commit();
    wrap_frame(1'b1);
    data_index = 4'd5;
    #1;
    total++;
    if (data_in !== 24'hFE0200) $display("FAIL scale_literal got=%h want=fe0200", data_in);
    else passed++;
    check_frame("scaling");
  endtask

  task automatic test_gating();
    int swaps;
    write_px(4'd6, 24'h123456, 8'd200, 1'b0);
    do_commit();
    data_index = 4'd2;
    swaps = 0;
    // A write attempted while pending must not be accepted.
    wr_valid = 1'b1; wr_addr = 4'd1; wr_rgb = 24'hABCDEF; brightness = 8'd255;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (swap === 1'b1) swaps++;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    total++;
    if (swaps != 0) $display("FAIL gate_no_swap got=%0d want=0", swaps);
    else passed++;
    total++;
    if (wr_ready !== 1'b0 || commit_pending !== 1'b1 || wr_error !== 1'b0)
      $display("FAIL gate_hold ready=%b pending=%b err=%b want 0/1/0", wr_ready, commit_pending, wr_error);
    else passed++;
    data_index = 4'd6;
    #1;
    total++;
    if (data_in !== model_bank[model_sel][6])
      $display("FAIL gate_active got=%h want=%h", data_in, model_bank[model_sel][6]);
    else passed++;
    wrap_frame(1'b1);
    swaps = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (swap === 1'b1) swaps++;
      tick();
    end
    total++;
    if (swaps != 0) $display("FAIL gate_single_pulse extra=%0d want=0", swaps);
    else passed++;
    check_frame("gating");
  endtask

  task automatic test_simultaneous();
    data_index = 4'd7;
    tick();
    write_px(4'd0, 24'h00FF00, 8'd255, 1'b1);
    data_index = 4'd0;
    #1;
    total++;
    if (swap !== 1'b1) $display("FAIL simul_swap got=%b want=1", swap);
    else passed++;
    tick();
    model_sel = !model_sel;
    check_frame("simultaneous");
  endtask

  task automatic test_back_to_back();
    logic [23:0] rgb;
    logic [7:0]  br;
    for (int i = 0; i < N; i++) begin
      rgb = 24'($urandom);
      br  = 8'($urandom_range(0, 255));
      if (i == 0) br = 8'd0;
      if (i == 1) br = 8'd255;
      write_px(4'(i), rgb, br, 1'b0);
    end
    do_commit();
    wrap_frame(1'b1);
    check_frame("back_to_back");
  endtask

  task automatic test_out_of_range();
    write_px(4'd9, 24'hFFFFFF, 8'd255, 1'b0);
    tick();
    total++;
    if (wr_error !== 1'b0) $display("FAIL oor_pulse_width got=%b want=0", wr_error);
    else passed++;
    do_commit();
    wrap_frame(1'b1);
    check_frame("out_of_range");
  endtask

  task automatic test_mid_reset();
    write_px(4'd2, 24'h0F0F0F, 8'd255, 1'b0);
    do_commit();
    data_index = 4'd7;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    tick();
    data_index = 4'd0;
    #1;
    total++;
    if (swap !== 1'b0 || commit_pending !== 1'b0)
      $display("FAIL mid_reset swap=%b pending=%b want 0/0", swap, commit_pending);
    else passed++;
    tick();
    check_frame("mid_reset");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_commit();
    test_scaling();
    test_gating();
    test_simultaneous();
    test_back_to_back();
    test_out_of_range();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ws2812_pixel_buffer.md
# ws2812_pixel_buffer

Double-buffered pixel store feeding the WS2812 serial controller. Host logic writes RGB pixels into a shadow bank through a valid/ready port. Each write is brightness-scaled and reordered into the controller's bit-serial order. A commit request swaps shadow and active banks only at a frame boundary, detected from the controller's `data_index` wrap. The controller never sees a half-updated frame.

## Interface
- `RGB_NUM_WIDTH`, 4, width of pixel address / `data_index`
- `RGB_NUM`, 8, number of pixels in the chain (≤ 2^RGB_NUM_WIDTH)

Ports:
- `clock` in 1: system clock (50 MHz)
- `reset` in 1: synchronous, active-high reset
- `wr_valid` in 1: pixel write request
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`
- `wr_addr` in RGB_NUM_WIDTH: pixel index
- `wr_rgb` in 24: {R[23:16], G[15:8], B[7:0]}
- `brightness` in 8: global scale, sampled on write acceptance
- `commit` in 1: request bank swap (level sampled each cycle)
- `commit_pending` out 1: swap requested, not yet performed
- `swap` out 1: one-cycle pulse on the cycle the swap occurs
- `wr_error` out 1: one-cycle pulse for an accepted write with `wr_addr >= RGB_NUM`
- `data_index` in RGB_NUM_WIDTH: pixel index from the controller
- `data_in` out 24: active-bank pixel in serial order; connects to the controller's `data_in`

## Operation
- **Banks.**
  - Two banks of RGB_NUM × 24-bit registers, plus a 1-bit `sel` register.
  - The active bank is `bank[sel]`; the shadow bank is `bank[~sel]`.
- **Write stage 1 (acceptance cycle).** Capture addr, scaled channels, and stage-valid into a pipeline register.
  - Scaling per channel: out = (c × (brightness + 1)) >> 8.
  - The 17-bit product keeps bits [15:8].
  - brightness 255 gives identity; brightness 0 gives 0.
- **Write stage 2 (next cycle).** Write the stage register into `bank[~sel]` using the `sel` value before any same-edge swap.
  - Out-of-range addr: do not write; pulse `wr_error` in stage 2.
- **Stored word order** (controller transmits bit 0 first, WS2812 expects G7 first):
  - word[7:0] = G[7:0] bit-reversed (word[0] = G7)
  - word[15:8] = R bit-reversed (word[8] = R7)
  - word[23:16] = B bit-reversed (word[16] = B7)
- **wr_ready** = !commit_pending.
- **Commit.**
  - `commit` high in a cycle sets `commit_pending` at the next edge.
  - While pending, further `commit` is ignored.
  - A write accepted in the same cycle as `commit` is included in the committed frame.
- **Frame boundary.**
  - Register `idx_q <= data_index`.
  - `frame_done` = (idx_q == RGB_NUM−1) && (data_index == 0).
- **Swap.** At an edge where `commit_pending && frame_done`: `sel <= ~sel`, `commit_pending <= 0`, and `swap` pulses high for that cycle (combinational from the same condition).
- **Read path (combinational).** `data_in = bank[sel][data_index]`; `data_index >= RGB_NUM` gives 24'h0.
- **After a swap**, the new shadow holds the frame before last. Writers rewrite every pixel they need.
- **Reset.**
  - Both banks 0, `sel`=0, `commit_pending`=0, stage invalid, `idx_q`=0.
  - Outputs: `wr_ready`=1, `swap`=0, `wr_error`=0, `data_in`=0.
  - Reset mid-frame or mid-commit discards the pending swap and all staged writes.

## Timing
- Write latency: acceptance at edge N; shadow updated at edge N+1; visible on `data_in` only after a swap.
- Commit at cycle N: `commit_pending`=1 from N+1; `wr_ready`=0 from N+1.
- Earliest possible swap edge is end of N+1. A stage-2 write in N+1 still lands in the bank that becomes active.
- `data_in` follows `data_index` and `sel` with zero-cycle combinational delay. The controller samples it on its own divided-clock edges.
- `frame_done` requires `data_index` held at RGB_NUM−1 for at least one `clock` cycle before it wraps; the controller guarantees ≥20 cycles.
- Swap and `wr_error` pulses are exactly one cycle wide.

## Test plan
- **Reset defaults.** Assert `reset` 2 cycles → `data_in`=0 for all indices, `wr_ready`=1, `commit_pending`=0.
- **Write, commit, wrap.**
  - Stimulus: write addr 3 = 24'hFF0000, brightness 255, commit; drive `data_index` 7→0.
  - Required: `swap` pulse; with `data_index`=3, `data_in` = 24'h00FF00 (R bits at [15:8]).
  - Other indices read 0.
- **Scaling and order.**
  - Stimulus: write {R=8'h80, G=8'h01, B=8'hFF}, brightness 127, commit, wrap.
  - Scaled: R=8'h40, G=8'h00, B=8'h7F → `data_in` = {8'hFE, 8'h02, 8'h00}.
- **Commit-boundary gating.** Commit, then hold `data_index` at 2 for 100 cycles → no swap, `wr_ready`=0, active bank unchanged. Then 7→0 → single `swap` pulse, `wr_ready`=1 next cycle.
- **Simultaneous write + commit.** Write addr 0 in the same cycle as `commit`, wrap on the following cycle → the new value appears at index 0 after the swap.
- **Out-of-range and mid-reset.**
  - Write addr 9 → `wr_error` pulse 1 cycle later; no bank changes.
  - Commit, then `reset` before the wrap → no swap, `commit_pending`=0, all reads 0.
